// File: rtl/servant_spi_mem.sv
// servant_spi_mem: Wishbone-to-SPI memory bridge for the servant SoC.
// Each Wishbone access becomes one SPI frame: a command byte, then
// ADDR_BYTES address bytes (MSB first), then the data bytes.
// Reads use 0x03 and return 4 bytes. Writes use 0x02 and send only the
// span of byte lanes between the lowest and highest selected lane.
// Optional feature: define SERVANT_SPI_FAST_READ_EN to issue reads as
// FAST READ (0x0B) with one 0x00 dummy byte after the address.
module servant_spi_mem #(
  parameter int ADDR_BYTES = 3,
  parameter int CLK_DIV    = 1
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [29:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        spi_sck,
  output logic        spi_ss,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  // Handshake: i_wb_cyc acts as "valid"; it is sampled only in IDLE, and the
  // master holds it until o_wb_ack. o_wb_ack is a one-cycle completion pulse
  // that also marks o_wb_rdt as valid for reads. Changes to the request
  // inputs after the sampling edge are ignored.

  localparam int AW = 8 * ADDR_BYTES;
  localparam int FW = 72;  // longest frame: cmd + 3 addr + dummy + 4 data

`ifdef SERVANT_SPI_FAST_READ_EN
  localparam logic [7:0] RD_CMD     = 8'h0B;
  localparam int         DUMMY_BITS = 8;
`else
  localparam logic [7:0] RD_CMD     = 8'h03;
  localparam int         DUMMY_BITS = 0;
`endif
  localparam logic [7:0] WR_CMD    = 8'h02;
  localparam logic [6:0] RD_NBITS  = 7'(8 * (1 + ADDR_BYTES + 4) + DUMMY_BITS);
  localparam logic [6:0] RD_DSTART = 7'(8 * (1 + ADDR_BYTES) + DUMMY_BITS);
  localparam logic [6:0] WR_DSTART = 7'(8 * (1 + ADDR_BYTES));
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0]    r_div;     // wb_clk count within the current SCK phase
  logic          r_phase;   // 0: SCK low half, 1: SCK high half
  logic [6:0]    r_bit;     // index of the bit being shifted
  logic [6:0]    r_nbits;   // frame length in bits
  logic [6:0]    r_dstart;  // first bit index of the data phase
  logic          r_we;
  logic [FW-1:0] r_shift;   // outgoing frame, left aligned
  logic [31:0]   r_rx;      // incoming read bytes, first byte in the top
  logic [31:0]   r_rdt;

  logic [31:0]   w_byte_adr;
  logic [1:0]    w_lo;
  logic [1:0]    w_hi;
  logic [1:0]    w_lo_eff;
  logic [2:0]    w_ndata;
  logic [AW-1:0] w_spi_addr;
  logic [31:0]   w_dat_shr;
  logic [31:0]   w_wdata;
  logic          w_noop;
  logic [FW-1:0] w_frame;
  logic [6:0]    w_nbits;
  logic [6:0]    w_dstart;
  logic          w_active;
  logic          w_div_end;
  logic          w_bit_end;
  logic          w_last_bit;
  logic [31:0]   w_rx_swapped;
  logic          w_unused;

  // Request decode: byte address, lane span and frame image.
  assign w_byte_adr = {i_wb_adr, 2'b00};
  assign w_unused   = ^w_byte_adr[31:AW];

  // Lowest and highest selected byte lane.
  always_comb begin
    w_lo = 2'd3;
    if (i_wb_sel[0])      w_lo = 2'd0;
    else if (i_wb_sel[1]) w_lo = 2'd1;
    else if (i_wb_sel[2]) w_lo = 2'd2;
    w_hi = 2'd0;
    if (i_wb_sel[3])      w_hi = 2'd3;
    else if (i_wb_sel[2]) w_hi = 2'd2;
    else if (i_wb_sel[1]) w_hi = 2'd1;
  end

  // Reads always start at lane 0; sel only shapes writes.
  assign w_lo_eff     = i_wb_we ? w_lo : 2'd0;
  assign w_ndata      = {1'b0, w_hi} - {1'b0, w_lo} + 3'd1;
  assign w_spi_addr   = w_byte_adr[AW-1:0] + {{(AW-2){1'b0}}, w_lo_eff};
  assign w_dat_shr    = i_wb_dat >> {w_lo, 3'b000};
  assign w_wdata      = {w_dat_shr[7:0], w_dat_shr[15:8], w_dat_shr[23:16], w_dat_shr[31:24]};
  assign w_noop       = i_wb_we && (i_wb_sel == 4'b0000);
  assign w_rx_swapped = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};

  // Frame image and length; read dummy and data slots shift out as zero.
  always_comb begin
    if (i_wb_we) begin
      w_frame  = {WR_CMD, w_spi_addr, w_wdata, {(FW - AW - 40){1'b0}}};
      w_nbits  = WR_DSTART + {1'b0, w_ndata, 3'b000};
      w_dstart = WR_DSTART;
    end else begin
      w_frame  = {RD_CMD, w_spi_addr, {(FW - AW - 8){1'b0}}};
      w_nbits  = RD_NBITS;
      w_dstart = RD_DSTART;
    end
  end

  assign w_active   = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_div_end  = (r_div == DIV_LAST);
  assign w_bit_end  = r_phase && w_div_end;
  assign w_last_bit = (r_bit == r_nbits - 7'd1);

  // State register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state: phases advance at the end of a bit's SCK-high half.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (i_wb_cyc) w_state_next = w_noop ? S_DONE : S_CMD;
      S_CMD:  if (w_bit_end && (r_bit == 7'd7)) w_state_next = S_ADDR;
      S_ADDR: if (w_bit_end && (r_bit == r_dstart - 7'd1)) w_state_next = S_DATA;
      S_DATA: if (w_bit_end && w_last_bit) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs: pins are driven only while a frame is on the bus.
  always_comb begin
    spi_ss   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    o_wb_ack = 1'b0;
    case (r_state)
      S_CMD, S_ADDR, S_DATA: begin
        spi_ss   = 1'b0;
        spi_sck  = r_phase;
        spi_mosi = r_shift[FW-1];
      end
      S_DONE:  o_wb_ack = 1'b1;
      default: ;
    endcase
  end

  assign o_wb_rdt = r_rdt;

  // Datapath: latch the request, time SCK, shift MOSI and capture MISO.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_div    <= 8'd0;
      r_phase  <= 1'b0;
      r_bit    <= 7'd0;
      r_nbits  <= 7'd0;
      r_dstart <= 7'd0;
      r_we     <= 1'b0;
      r_shift  <= '0;
      r_rx     <= 32'd0;
      r_rdt    <= 32'd0;
    end else if (r_state == S_IDLE) begin
      if (i_wb_cyc) begin
        r_shift  <= w_frame;
        r_nbits  <= w_nbits;
        r_dstart <= w_dstart;
        r_we     <= i_wb_we;
        r_div    <= 8'd0;
        r_phase  <= 1'b0;
        r_bit    <= 7'd0;
      end
    end else if (w_active) begin
      if (w_div_end) begin
        r_div   <= 8'd0;
        r_phase <= ~r_phase;
        if (!r_phase) begin
          // SCK rises on this edge: sample MISO during the data phase.
          if (r_state == S_DATA) r_rx <= {r_rx[30:0], spi_miso};
        end else begin
          // SCK falls on this edge: present the next MOSI bit.
          r_shift <= r_shift << 1;
          r_bit   <= r_bit + 7'd1;
          if (w_last_bit && !r_we) r_rdt <= w_rx_swapped;
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

endmodule
